// File: rtl/ysyx_25040111_pkg.sv
// rtl/ysyx_25040111_pkg.sv - shared encodings, CSR addresses and FSM states for the trap controller
package ysyx_25040111_pkg;

    localparam int XLEN = 32;

    // execute-stage operation encodings (6 and 7 are illegal)
    localparam logic [2:0] OP_CSRRW  = 3'd0;
    localparam logic [2:0] OP_CSRRS  = 3'd1;
    localparam logic [2:0] OP_CSRRC  = 3'd2;
    localparam logic [2:0] OP_ECALL  = 3'd3;
    localparam logic [2:0] OP_EBREAK = 3'd4;
    localparam logic [2:0] OP_MRET   = 3'd5;

    // machine-mode CSR addresses touched by the controller
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MVENDID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID = 12'hF12;

    // mcause codes
    localparam logic [3:0] CAUSE_ILLEGAL = 4'h2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'h3;
    localparam logic [3:0] CAUSE_ECALL   = 4'hB;

    // mstatus bit positions
    localparam int MST_MIE    = 3;
    localparam int MST_MPIE   = 7;
    localparam int MST_MPP_LO = 11;
    localparam int MST_MPP_HI = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CSR_R = 3'd1,
        S_CSR_W = 3'd2,
        S_EPC   = 3'd3,
        S_MST_R = 3'd4,
        S_MST_W = 3'd5,
        S_VEC   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

    // anything that is neither a CSR op nor MRET traps; only ECALL/EBREAK have their own cause
    function automatic logic [3:0] trap_cause(input logic [2:0] op);
        case (op)
            OP_ECALL:  return CAUSE_ECALL;
            OP_EBREAK: return CAUSE_EBREAK;
            default:   return CAUSE_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25040111_trap_ctrl_if.sv
// rtl/ysyx_25040111_trap_ctrl_if.sv - execute-side request/response handshake bundle
interface ysyx_25040111_trap_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [11:0] in_csr_addr;
    logic [31:0] in_rs1_val;
    logic        in_rs1_is_x0;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd_data;
    logic        out_redirect;
    logic [31:0] out_redirect_pc;

    // execute stage side
    modport master (
        output in_valid, in_op, in_csr_addr, in_rs1_val, in_rs1_is_x0, in_pc, out_ready,
        input  in_ready, out_valid, out_rd_data, out_redirect, out_redirect_pc
    );

    // trap controller side
    modport slave (
        input  in_valid, in_op, in_csr_addr, in_rs1_val, in_rs1_is_x0, in_pc, out_ready,
        output in_ready, out_valid, out_rd_data, out_redirect, out_redirect_pc
    );
endinterface

// File: rtl/ysyx_25040111_mstatus_upd.sv
// rtl/ysyx_25040111_mstatus_upd.sv - mstatus stacking for trap entry and MRET
module ysyx_25040111_mstatus_upd
    import ysyx_25040111_pkg::*;
(
    input  logic [31:0] old_mstatus,
    input  logic        is_mret,
    output logic [31:0] new_mstatus
);

    // push MIE into MPIE on trap, pop it back on MRET; MPP always reads machine mode
    always_comb begin
        new_mstatus = old_mstatus;
        if (is_mret) begin
            new_mstatus[MST_MIE]  = old_mstatus[MST_MPIE];
            new_mstatus[MST_MPIE] = 1'b1;
        end else begin
            new_mstatus[MST_MPIE] = old_mstatus[MST_MIE];
            new_mstatus[MST_MIE]  = 1'b0;
        end
        new_mstatus[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    end

endmodule

// File: rtl/ysyx_25040111_trap_ctrl.sv
// rtl/ysyx_25040111_trap_ctrl.sv - multi-cycle CSR read-modify-write, trap entry and MRET sequencer
module ysyx_25040111_trap_ctrl
    import ysyx_25040111_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    ysyx_25040111_trap_ctrl_if.slave exe,
    output logic                  csr_wen,
    output logic [11:0]           csr_waddr,
    output logic [31:0]           csr_wdata,
    output logic                  csr_ren,
    output logic [11:0]           csr_raddr,
    input  logic [31:0]           csr_rdata,
    output logic                  csr_err,
    output logic [3:0]            csr_errtp
);

    state_t      state;
    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] rs1_q;
    logic        x0_q;
    logic [31:0] old_q;

    logic        is_mret_q;
    logic        csr_ro;
    logic        csr_wr_ok;
    logic [31:0] csr_new;
    logic [31:0] mst_new;

    assign is_mret_q = (op_q == OP_MRET);
    // read-only ID registers are never written; RS/RC with rs1=x0 are pure reads
    assign csr_ro    = (addr_q == CSR_MVENDID) || (addr_q == CSR_MARCHID);
    assign csr_wr_ok = !csr_ro && !((op_q != OP_CSRRW) && x0_q);

    // new CSR value computed straight from the read port while in CSR_R
    always_comb begin
        case (op_q)
            OP_CSRRS: csr_new = csr_rdata | rs1_q;
            OP_CSRRC: csr_new = csr_rdata & ~rs1_q;
            default:  csr_new = rs1_q;
        endcase
    end

    ysyx_25040111_mstatus_upd u_mstatus_upd (
        .old_mstatus (csr_rdata),
        .is_mret     (is_mret_q),
        .new_mstatus (mst_new)
    );

    // sequencer: every strobe is registered on entry to the state that owns it, so each is a one-cycle pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= S_IDLE;
            op_q                <= 3'd0;
            addr_q              <= 12'd0;
            rs1_q               <= 32'd0;
            x0_q                <= 1'b0;
            old_q               <= 32'd0;
            exe.in_ready        <= 1'b1;
            exe.out_valid       <= 1'b0;
            exe.out_rd_data     <= 32'd0;
            exe.out_redirect    <= 1'b0;
            exe.out_redirect_pc <= 32'd0;
            csr_wen             <= 1'b0;
            csr_waddr           <= 12'd0;
            csr_wdata           <= 32'd0;
            csr_ren             <= 1'b0;
            csr_raddr           <= 12'd0;
            csr_err             <= 1'b0;
            csr_errtp           <= 4'd0;
        end else begin
            csr_wen   <= 1'b0;
            csr_waddr <= 12'd0;
            csr_wdata <= 32'd0;
            csr_ren   <= 1'b0;
            csr_raddr <= 12'd0;
            csr_err   <= 1'b0;
            csr_errtp <= 4'd0;
            case (state)
                S_IDLE: begin
                    if (exe.in_valid) begin
                        op_q         <= exe.in_op;
                        addr_q       <= exe.in_csr_addr;
                        rs1_q        <= exe.in_rs1_val;
                        x0_q         <= exe.in_rs1_is_x0;
                        exe.in_ready <= 1'b0;
                        if (is_csr_op(exe.in_op)) begin
                            state     <= S_CSR_R;
                            csr_ren   <= 1'b1;
                            csr_raddr <= exe.in_csr_addr;
                        end else if (exe.in_op == OP_MRET) begin
                            state     <= S_MST_R;
                            csr_ren   <= 1'b1;
                            csr_raddr <= CSR_MSTATUS;
                        end else begin
                            state     <= S_EPC;
                            csr_wen   <= 1'b1;
                            csr_waddr <= CSR_MEPC;
                            csr_wdata <= exe.in_pc;
                            csr_err   <= 1'b1;
                            csr_errtp <= trap_cause(exe.in_op);
                        end
                    end
                end
                S_CSR_R: begin
                    old_q <= csr_rdata;
                    state <= S_CSR_W;
                    if (csr_wr_ok) begin
                        csr_wen   <= 1'b1;
                        csr_waddr <= addr_q;
                        csr_wdata <= csr_new;
                    end
                end
                S_CSR_W: begin
                    state               <= S_DONE;
                    exe.out_valid       <= 1'b1;
                    exe.out_rd_data     <= old_q;
                    exe.out_redirect    <= 1'b0;
                    exe.out_redirect_pc <= 32'd0;
                end
                S_EPC: begin
                    state     <= S_MST_R;
                    csr_ren   <= 1'b1;
                    csr_raddr <= CSR_MSTATUS;
                end
                S_MST_R: begin
                    state     <= S_MST_W;
                    csr_wen   <= 1'b1;
                    csr_waddr <= CSR_MSTATUS;
                    csr_wdata <= mst_new;
                end
                S_MST_W: begin
                    state     <= S_VEC;
                    csr_ren   <= 1'b1;
                    csr_raddr <= is_mret_q ? CSR_MEPC : CSR_MTVEC;
                end
                S_VEC: begin
                    state               <= S_DONE;
                    exe.out_valid       <= 1'b1;
                    exe.out_rd_data     <= 32'd0;
                    exe.out_redirect    <= 1'b1;
                    // only direct-mode mtvec is supported, so the mode bits are dropped
                    exe.out_redirect_pc <= is_mret_q ? csr_rdata : {csr_rdata[31:2], 2'b00};
                end
                S_DONE: begin
                    if (exe.out_ready) begin
                        state               <= S_IDLE;
                        exe.in_ready        <= 1'b1;
                        exe.out_valid       <= 1'b0;
                        exe.out_rd_data     <= 32'd0;
                        exe.out_redirect    <= 1'b0;
                        exe.out_redirect_pc <= 32'd0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    exe.in_ready  <= 1'b1;
                    exe.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
